multiword_add_seq: RTL and testbench



---
 rtl/multiword_add_seq.sv | 149 ++++++++++++++
 tb/tb_multiword_add_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: streams N*WORDS-bit operands LS word first through one
// N-bit adder, keeping the inter-word carry in a register. Results leave via
// a one-entry valid/ready output buffer; done pulses once the final word is
// consumed and cout is then updated.
// Optional macro MULTIWORD_ADD_SEQ_OVF_EN adds the signed-overflow output ovf.
module multiword_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cin,
    output logic         busy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_last,
    output logic         cout,
    output logic         done
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          last_q, last_d;
    logic          cout_q, cout_d;
    logic          done_q, done_d;
    logic [N:0]    add_w;
    logic          push, pop;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    logic          ovf_pend_q, ovf_pend_d;
    logic          ovf_q, ovf_d;
`endif

    // The buffer can take a new word when empty or being drained this cycle.
    assign in_ready = (state_q == S_RUN) && (!valid_q || out_ready);
    assign push     = in_valid && in_ready;
    assign pop      = valid_q && out_ready;
    assign add_w    = {1'b0, in_a} + {1'b0, in_b} + (N+1)'(carry_q);

    assign busy      = (state_q != S_IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_last  = last_q;
    assign cout      = cout_q;
    assign done      = done_q;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

    // Next-state logic: sequencing, carry chaining and output buffer control.
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
`endif
        // A pop empties the buffer unless a push refills it below.
        if (pop) valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    {carry_d, sum_d} = add_w;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == LAST_CNT);
                    cnt_d   = cnt_q + CW'(1);
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit.
                    ovf_pend_d = (in_a[N-1] ^ in_b[N-1] ^ add_w[N-1]) ^ add_w[N];
`endif
                    if (cnt_q == LAST_CNT) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && last_q) begin
                    done_d  = 1'b1;
                    cout_d  = carry_q;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
                    ovf_d   = ovf_pend_q;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; a reset drops any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (N=8, WORDS=4): directed vector
// table, reset/busy sequences, and randomized ops against an arithmetic model.
module tb_multiword_add_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int TOT   = N * WORDS;

    logic         clk = 1'b0;
    logic         rst, start, cin, busy, in_valid, in_ready;
    logic [N-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_last, cout, done;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    logic last_cout = 1'b0;
    logic last_ovf  = 1'b0;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .cin(cin), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .cout(cout), .done(done)
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic get_ovf();
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic [TOT-1:0] a;
        logic [TOT-1:0] b;
        logic           c;
        int             mode;  // 0 full rate, 1 random, 2 backpressure, 3 start while busy
        logic [TOT-1:0] s;
        logic           co;
        logic           ov;
    } vec_t;

    // Runs one operation; collects popped words and the final cout/ovf.
    task automatic run_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic c,
                          input int mode, output logic [TOT-1:0] s_got,
                          output logic co_got, output logic ov_got);
        int wi, wo, cyc, stall;
        logic prev_push, prev_hold, done_seen;
        logic [N-1:0] prev_sum;
        s_got = '0; co_got = 1'b0; ov_got = 1'b0;
        wi = 0; wo = 0; cyc = 0; stall = 0;
        prev_push = 1'b0; prev_hold = 1'b0; done_seen = 1'b0; prev_sum = '0;
        @(negedge clk);
        start = 1'b1; cin = c; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; cin = 1'($urandom);
        while (!done_seen && cyc < 200) begin
            if (done) begin
                done_seen = 1'b1;
                chk("done_after_last_word", 64'(wo), 64'(WORDS));
                chk("busy_at_done", 64'(busy), 64'(0));
                co_got = cout;
                ov_got = get_ovf();
                if (mode == 0) chk("min_latency", 64'(cyc), 64'(WORDS + 1));
            end else begin
                chk("cout_hold", 64'(cout), 64'(last_cout));
                chk("ovf_hold", 64'(get_ovf()), 64'(last_ovf));
                chk("busy_running", 64'(busy), 64'(1));
                if (prev_push) chk("out_valid_after_push", 64'(out_valid), 64'(1));
                if (prev_hold) begin
                    chk("out_valid_held", 64'(out_valid), 64'(1));
                    chk("out_sum_stable", 64'(out_sum), 64'(prev_sum));
                end
                start = (mode == 3 && cyc == 1);
                if (start) cin = ~c;
                in_valid = (wi < WORDS) && (mode != 1 || $urandom_range(0, 3) != 0);
                if (wi < WORDS) begin
                    in_a = a[wi*N +: N];
                    in_b = b[wi*N +: N];
                end else begin
                    in_a = N'($urandom);
                    in_b = N'($urandom);
                end
                if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
                else if (mode == 2 && out_valid && stall < 3) begin
                    out_ready = 1'b0;
                    stall++;
                end else out_ready = 1'b1;
                #1;
                if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'(0));
                if (mode == 0 && wi < WORDS) chk("full_throughput", 64'(in_ready), 64'(1));
                prev_push = in_valid && in_ready;
                if (prev_push) wi++;
                if (out_valid && out_ready) begin
                    if (wo < WORDS) s_got[wo*N +: N] = out_sum;
                    chk("out_last", 64'(out_last), 64'(wo == WORDS - 1));
                    wo++;
                end
                prev_hold = out_valid && !out_ready;
                prev_sum  = out_sum;
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        if (!done_seen) begin
            chk("op_timeout", 64'(0), 64'(1));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            last_cout = 1'b0;
            last_ovf  = 1'b0;
        end else begin
            @(negedge clk);
            chk("done_pulse", 64'(done), 64'(0));
            chk("cout_after_done", 64'(cout), 64'(co_got));
            last_cout = co_got;
            last_ovf  = ov_got;
        end
    endtask

    vec_t vecs[7];

    initial begin
        logic [TOT-1:0] s_got, ea, eb;
        logic co_got, ov_got, ec;
        logic [TOT:0] usum;
        logic signed [TOT:0] ssum;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h000000FF, 32'h00000001, 1'b0, 2, 32'h00000100, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 3, 32'hACF13569, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 2, 32'h00000000, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; cin = 1'b0; in_valid = 1'b1;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_in_ready", 64'(in_ready), 64'(0));
            chk("idle_out_valid", 64'(out_valid), 64'(0));
            chk("idle_out_sum", 64'(out_sum), 64'(0));
            chk("idle_out_last", 64'(out_last), 64'(0));
            chk("idle_cout", 64'(cout), 64'(0));
            chk("idle_done", 64'(done), 64'(0));
            chk("idle_ovf", 64'(get_ovf()), 64'(0));
        end
        in_valid = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].mode, s_got, co_got, ov_got);
            chk($sformatf("vec%0d_sum", i), 64'(s_got), 64'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(co_got), 64'(vecs[i].co));
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 64'(ov_got), 64'(vecs[i].ov));
`endif
        end

        // Reset after two accepted words: output discarded, no done pulse.
        @(negedge clk);
        start = 1'b1; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1; in_a = N'(8'h11 * (w + 1)); in_b = 8'h01;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        repeat (3) begin
            chk("rst_no_done", 64'(done), 64'(0));
            @(negedge clk);
        end
        run_op(32'h000000FF, 32'h00000001, 1'b0, 0, s_got, co_got, ov_got);
        chk("post_rst_sum", 64'(s_got), 64'(32'h00000100));
        chk("post_rst_cout", 64'(co_got), 64'(0));

        // Randomized operations against a plain arithmetic model.
        for (int k = 0; k < 25; k++) begin
            ea = TOT'($urandom);
            eb = TOT'($urandom);
            ec = 1'($urandom);
            usum = {1'b0, ea} + {1'b0, eb} + (TOT+1)'(ec);
            ssum = $signed({ea[TOT-1], ea}) + $signed({eb[TOT-1], eb}) + $signed({{TOT{1'b0}}, ec});
            run_op(ea, eb, ec, $urandom_range(0, 3), s_got, co_got, ov_got);
            chk($sformatf("rand%0d_sum", k), 64'(s_got), 64'(usum[TOT-1:0]));
            chk($sformatf("rand%0d_cout", k), 64'(co_got), 64'(usum[TOT]));
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
            chk($sformatf("rand%0d_ovf", k), 64'(ov_got), 64'(ssum[TOT] != ssum[TOT-1]));
`endif
        end

        repeat (3) begin
            @(negedge clk);
            chk("final_cout_hold", 64'(cout), 64'(last_cout));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
